// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the Avalon interrupt controller: register map indices
// and claim-word layout.
package irq_ctrl_pkg;

  localparam logic [1:0]  REG_PENDING     = 2'd0;
  localparam logic [1:0]  REG_ENABLE      = 2'd1;
  localparam logic [1:0]  REG_TYPE        = 2'd2;
  localparam logic [1:0]  REG_CLAIM       = 2'd3;

  localparam int unsigned CLAIM_VALID_BIT = 31;
  localparam int unsigned ID_W_DEF        = 5;
  localparam int unsigned DATA_W          = 32;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports the lowest set index of i_req.
module irq_prio_enc #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 5
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic [ID_W-1:0]    o_id_c,
  output logic               o_valid_c
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_id_c    = '0;
    o_valid_c = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id_c    = ID_W'(i);
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avalon_irq_ctrl.sv
// Interrupt aggregator with per-source enable and edge/level type, a
// registered CPU irq line and an Avalon-MM register window with a claim port.
module avalon_irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = ID_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_n,
  input  logic                write_n,
  input  logic [DATA_W-1:0]   address,
  input  logic [DATA_W-1:0]   writeData,
  output logic [DATA_W-1:0]   readData,
  input  logic [NUM_SRC-1:0]  irq_src,
  output logic                irq
);

  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_type;
  logic [DATA_W-1:0]  r_read_data;
  logic               r_irq;

  logic               w_rd;
  logic               w_wr;
  logic [1:0]         w_sel;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pending_nxt;
  logic [DATA_W-1:0]  w_rdata;
  logic [ID_W-1:0]    w_id;
  logic               w_valid;
  logic               w_unused;

  assign w_rd     = ~read_n;
  assign w_wr     = ~write_n;
  assign w_sel    = address[3:2];
  assign w_rise   = irq_src & ~r_prev;
  assign w_active = r_pending & r_enable;
  assign w_unused = ^{address[DATA_W-1:4], address[1:0], writeData};

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .i_req     (w_active),
    .o_id_c    (w_id),
    .o_valid_c (w_valid)
  );

  // Edge sources: set on rise, clear on W1C or claim, set wins. Level sources track the pin.
  always_comb begin
    w_clr = '0;
    if (w_wr && (w_sel == REG_PENDING)) begin
      w_clr = writeData[NUM_SRC-1:0];
    end
    if (w_rd && (w_sel == REG_CLAIM) && w_valid) begin
      w_clr = w_clr | (NUM_SRC'(1) << w_id);
    end
    w_pending_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_pending_nxt[i] = r_type[i] ? (w_rise[i] | (r_pending[i] & ~w_clr[i]))
                                   : irq_src[i];
    end
  end

  // Read mux sees pre-write register values.
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_PENDING: w_rdata = DATA_W'(r_pending);
      REG_ENABLE:  w_rdata = DATA_W'(r_enable);
      REG_TYPE:    w_rdata = DATA_W'(r_type);
      REG_CLAIM: begin
        if (w_valid) begin
          w_rdata                  = DATA_W'(w_id);
          w_rdata[CLAIM_VALID_BIT] = 1'b1;
        end
      end
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev      <= '0;
      r_pending   <= '0;
      r_enable    <= '0;
      r_type      <= '0;
      r_read_data <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_prev    <= irq_src;
      r_pending <= w_pending_nxt;
      if (w_wr && (w_sel == REG_ENABLE)) begin
        r_enable <= writeData[NUM_SRC-1:0];
      end
      if (w_wr && (w_sel == REG_TYPE)) begin
        r_type <= writeData[NUM_SRC-1:0];
      end
      if (w_rd) begin
        r_read_data <= w_rdata;
      end
      r_irq <= |w_active;
    end
  end

  assign readData = r_read_data;
  assign irq      = r_irq;

endmodule
